jtframe_pocket_dlseq: RTL

Download sequencer between the Pocket bridge word stream and the JTFRAME ioctl byte interface. It accepts 32-bit bridge writes that are already synchronised to clk_rom and buffers them in a small word FIFO. It serialises each word into four ioctl byte writes, paced by the prog_rdy handshake from the SDRAM programmer. It owns the `downloading` flag, which falls only after the data-slot-complete event has arrived and all buffered data has been written.

---
 rtl/jtframe_pocket_dlseq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/jtframe_pocket_dlseq.sv
// Download sequencer: takes 32-bit bridge words (already in the clk_rom
// domain), queues them in a small word FIFO and replays each word as four
// ioctl byte writes, one per prog_rdy handshake from the SDRAM programmer.
//
// Handshake: ioctl_wr is a one-cycle strobe; ioctl_addr/ioctl_dout are valid
// with it and held stable until the next strobe. The programmer answers each
// strobe with a one-cycle prog_rdy pulse; only a pulse seen while waiting for
// an answer advances the sequencer, any other pulse is ignored.
module jtframe_pocket_dlseq #(
  parameter int          FIFO_AW   = 3,
  parameter int          MSB_FIRST = 0,
  parameter logic [7:0]  CMD_PAGE  = 8'hF8,
  parameter int          ADDR_W    = 25
) (
  input  logic              clk_rom,
  input  logic              rst,
  input  logic              wr_s,
  input  logic [31:0]       addr_s,
  input  logic [31:0]       data_s,
  input  logic              ds_done_s,
  input  logic              prog_rdy,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic              ioctl_wr,
  output logic              downloading,
  output logic              ovf,
  output logic [FIFO_AW:0]  fifo_lvl
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  state_t            state, state_nx;
  logic [54:0]       mem [DEPTH];
  logic [FIFO_AW:0]  wr_ptr, rd_ptr, lvl;
  logic [54:0]       head;
  logic              empty, full, accept, push, pop;
  logic [22:0]       word_addr;
  logic [31:0]       word_data;
  logic [1:0]        k;
  logic              ds_q, done_seen;
  logic              unused_addr_bit;

  // Bit 23 of the bridge address is outside the 8M-word download window.
  assign unused_addr_bit = addr_s[23];

  assign lvl      = wr_ptr - rd_ptr;
  assign fifo_lvl = lvl;
  assign empty    = (lvl == '0);
  assign full     = (lvl == (FIFO_AW+1)'(DEPTH));
  assign accept   = wr_s && (addr_s[31:24] != CMD_PAGE);
  assign push     = accept && !full;
  assign pop      = (state == LOAD);
  assign head     = mem[rd_ptr[FIFO_AW-1:0]];
  assign ioctl_wr = (state == SEND);

  // Byte address of byte kk within a word; wraps in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [22:0] a,
                                                  input logic [1:0]  kk);
    logic [24:0] base;
    base = {a, 2'b00};
    return ADDR_W'(base) + ADDR_W'(kk);
  endfunction

  // Byte kk of a word in transmission order.
  function automatic logic [7:0] byte_sel(input logic [31:0] w,
                                          input logic [1:0]  kk);
    logic [1:0] idx;
    idx = (MSB_FIRST != 0) ? 2'd3 - kk : kk;
    return w[8*idx +: 8];
  endfunction

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk_rom) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {addr_s[22:0], data_s};
  end

  // FIFO pointers and the sticky overflow flag.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (accept && full) ovf <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!empty) state_nx = LOAD;
      LOAD: state_nx = SEND;
      SEND: state_nx = WAIT;
      WAIT: if (prog_rdy) begin
              if (k != 2'd3)  state_nx = SEND;
              else if (!empty) state_nx = LOAD;
              else             state_nx = IDLE;
            end
      default: state_nx = IDLE;
    endcase
  end

  // Word register, byte counter and the registered ioctl address/data,
  // updated on every transition into SEND so they are valid with ioctl_wr.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      word_addr  <= '0;
      word_data  <= '0;
      k          <= '0;
      ioctl_addr <= '0;
      ioctl_dout <= '0;
    end else if (state == LOAD) begin
      word_addr  <= head[54:32];
      word_data  <= head[31:0];
      k          <= 2'd0;
      ioctl_addr <= byte_addr(head[54:32], 2'd0);
      ioctl_dout <= byte_sel(head[31:0], 2'd0);
    end else if (state == WAIT && prog_rdy && k != 2'd3) begin
      k          <= k + 2'd1;
      ioctl_addr <= byte_addr(word_addr, k + 2'd1);
      ioctl_dout <= byte_sel(word_data, k + 2'd1);
    end
  end

  // Download flag: raised by any accepted word, dropped once the slot-done
  // event has been seen and everything queued has been handed over.
  // A done edge in the same cycle as a word keeps done_seen set so the
  // download ends after that word drains.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      ds_q        <= 1'b0;
      done_seen   <= 1'b0;
      downloading <= 1'b0;
    end else begin
      ds_q <= ds_done_s;
      if (ds_done_s && !ds_q) done_seen <= 1'b1;
      else if (accept)        done_seen <= 1'b0;
      if (accept)
        downloading <= 1'b1;
      else if (done_seen && state == IDLE && empty)
        downloading <= 1'b0;
    end
  end

endmodule
